seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//   Parametrised serial bit-pattern detector, next generation of the fixed 101 Mealy detector.
//   Pattern width is set by parameter; the pattern can be reloaded at run time.
//   Overlapping or non-overlapping detection is selectable per cycle.
//   Outputs: a Mealy match pulse, a registered (Moore-timed) match and a saturating match counter.
//   Sits on a 1-bit serial input stream sampled on clk while en=1.
// PARAMETERS
//   N        3       pattern length in bits; legal range 2..32
//   PATTERN  3'b101  reset value of the pattern register, N bits; MSB is matched first
//   CNT_W    8       match counter width; legal range >=1
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-low
//   en         in   1      1 = x is a valid bit this cycle; 0 = stall, state held
//   x          in   1      serial data bit
//   overlap    in   1      1 = overlapping detection, 0 = non-overlapping
//   pat_load   in   1      load pat_in into the pattern register this cycle
//   pat_in     in   N      new pattern, MSB first
//   cnt_clr    in   1      synchronous clear of match_cnt
//   z          out  1      Mealy match: combinational from x/en, valid same cycle as the last bit
//   z_q        out  1      z registered; high exactly one cycle after z
//   match_cnt  out  CNT_W  number of matches, saturates at all-ones
// BEHAVIOUR
//   State
//     pat[N-1:0]: active pattern.
//     hist[N-1:0]: last accepted bits, newest bit in LSB.
//     fill: count of valid history bits, 0..N-1.
//   Reset (rst=0, async)
//     pat=PATTERN, hist=0, fill=0, z_q=0, match_cnt=0.
//     z=0, because fill=0.
//   Combinational Mealy output
//     cand = {hist[N-2:0], x}
//     z = en & ~pat_load & (fill == N-1) & (cand == pat)
//   Rising edge, in priority order
//     1. pat_load=1: pat<=pat_in; fill<=0; hist<=0. The x in that cycle is discarded; z=0.
//     2. en=1, no load:
//        - hist <= cand.
//        - if z & ~overlap: fill <= 0.
//        - otherwise: fill <= (fill == N-1) ? N-1 : fill+1.
//     3. en=0: hist and fill hold; z=0.
//   z_q <= z on every edge, independent of en.
//   match_cnt
//     - cnt_clr=1: match_cnt <= 0. Clear wins over a simultaneous match.
//     - else if z and match_cnt != all-ones: match_cnt <= match_cnt+1.
//     - At all-ones: holds.
//   overlap is sampled on the cycle of the match; changing it mid-stream affects only later matches.
//   Non-overlap: after a match, N fresh bits are needed before the next match can fire.
//   Overlap: back-to-back matches are possible, e.g. 1010 pattern with stream 101010 gives 2 matches.
//   en=0 gaps do not break a partial match; the bits before and after the gap are treated as contiguous.
//   Reset mid-stream discards the partial match and the pattern, and restores PATTERN.
//   Latency
//     z: 0 cycles after the last pattern bit is presented.
//     z_q and match_cnt: 1 cycle.
// TESTING
//   T1 overlap=1, N=3, pat=101, stream 1,0,1,0,1 -> z high on bits 3 and 5; match_cnt=2; z_q lags z by 1.
//   T2 overlap=0, same stream -> z high on bit 3 only; match_cnt=1.
//   T3 stream 1,0,(en=0 x3),1 -> z on the final bit; z=0 during the en=0 cycles even with x=1.
//   T4 pat_load with pat_in=110, x=1 in the load cycle -> that bit is ignored; then 1,1,0 -> z on the 3rd bit.
//   T5 CNT_W=2, overlap=1, stream 1,0,1,0,1,0,1,0,1,0,1 (5 matches) -> match_cnt 1,2,3,3,3; cnt_clr coincident with a match -> 0.
//   T6 stream 1,0 then rst low mid-cycle -> z=0, z_q=0, match_cnt=0 immediately; after release 1,0,1 -> z on bit 3, pattern back to PATTERN.

Source files
------------

// File: rtl/seq_detector_param.sv
// Purpose : parametrised serial bit-pattern detector with a run-time reloadable pattern.
// Latency : z is combinational (same cycle as the last bit); z_q and match_cnt follow one cycle later.
// Backpr. : none; en=0 stalls the detector and holds the history, and the bits on either side are contiguous.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   en         x carries a valid bit this cycle
//   x          serial data bit
//   overlap    1 = overlapping detection, 0 = non-overlapping (sampled on the match cycle)
//   pat_load   load pat_in as the active pattern; the x of that cycle is discarded
//   pat_in     new pattern, MSB matched first
//   cnt_clr    synchronous clear of match_cnt (wins over a coincident match)
//   z          Mealy match pulse
//   z_q        z registered
//   match_cnt  saturating match counter
module seq_detector_param #(
  parameter int              N       = 3,
  parameter logic [N-1:0]    PATTERN = 3'b101,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_cnt
);

  // fill counts valid history bits 0..N-1; N-1 history bits plus the
  // incoming x form a full N-bit candidate.
  localparam int                FILL_W   = (N > 2) ? $clog2(N) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [N-1:0]      pat_q,  pat_d;
  logic [N-1:0]      hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              z_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [N-1:0]      cand;

  // Candidate word: the N-1 most recent accepted bits followed by the current x.
  assign cand = {hist_q[N-2:0], x};

  // A load cycle never matches, so a stale candidate cannot fire against either pattern.
  assign z_d = en & ~pat_load & (fill_q == FILL_MAX) & (cand == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = cand;
      if (z_d && !overlap) begin
        // Non-overlapping: the matched bits are consumed, N fresh bits needed.
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (z_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
    end
  end

  assign z         = z_d;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  typedef struct {
    logic       en;
    logic       x;
    logic       ov;
    logic       ld;
    logic [2:0] pat;
    logic       clr;
    logic       ez;
    logic       ezq;
    logic [1:0] ecnt;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       x;
  logic       overlap;
  logic       pat_load;
  logic [2:0] pat_in;
  logic       cnt_clr;
  logic       z;
  logic       z_q;
  logic [1:0] match_cnt;

  int checks;
  int failures;
  vec_t vecs[$];

  seq_detector_param #(
    .N       (3),
    .PATTERN (3'b101),
    .CNT_W   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .x         (x),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .cnt_clr   (cnt_clr),
    .z         (z),
    .z_q       (z_q),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int e, int xi, int ov, int ld, int pat, int clr,
                              int ez, int ezq, int ecnt);
    vec_t v;
    v.en   = e[0];
    v.x    = xi[0];
    v.ov   = ov[0];
    v.ld   = ld[0];
    v.pat  = pat[2:0];
    v.clr  = clr[0];
    v.ez   = ez[0];
    v.ezq  = ezq[0];
    v.ecnt = ecnt[1:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled mid-cycle.
  task automatic step(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    en       = v.en;
    x        = v.x;
    overlap  = v.ov;
    pat_load = v.ld;
    pat_in   = v.pat;
    cnt_clr  = v.clr;
    #3;
    chk({tag, ".z"},   {31'd0, z},   {31'd0, v.ez});
    chk({tag, ".z_q"}, {31'd0, z_q}, {31'd0, v.ezq});
    chk({tag, ".cnt"}, {30'd0, match_cnt}, {30'd0, v.ecnt});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    en       = 1'b0;
    x        = 1'b0;
    overlap  = 1'b1;
    pat_load = 1'b0;
    pat_in   = 3'b000;
    cnt_clr  = 1'b0;

    // Fields: en x ov ld pat clr | exp z, exp z_q, exp match_cnt
    vecs.push_back(mk(0,0,1,0,0,0, 0,0,0));
    // T1 overlap, 1,0,1,0,1
    vecs.push_back(mk(1,1,1,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,1,0,0,0, 0,0,0));
    vecs.push_back(mk(1,1,1,0,0,0, 1,0,0));
    vecs.push_back(mk(1,0,1,0,0,0, 0,1,1));
    vecs.push_back(mk(1,1,1,0,0,0, 1,0,1));
    vecs.push_back(mk(0,0,1,0,0,0, 0,1,2));
    vecs.push_back(mk(0,0,1,0,0,1, 0,0,2));
    vecs.push_back(mk(1,1,0,1,5,0, 0,0,0));   // reload 101, x discarded
    // T2 non-overlap, 1,0,1,0,1 then 0,1
    vecs.push_back(mk(1,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 1,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,1,1));
    vecs.push_back(mk(1,1,0,0,0,0, 0,0,1));   // suppressed: only 2 fresh bits
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,1,0,0,0,0, 1,0,1));
    vecs.push_back(mk(0,1,0,1,5,0, 0,1,2));   // load works with en=0
    // T3 gap in stream
    vecs.push_back(mk(1,1,1,0,0,0, 0,0,2));
    vecs.push_back(mk(1,0,1,0,0,0, 0,0,2));
    vecs.push_back(mk(0,1,1,0,0,0, 0,0,2));
    vecs.push_back(mk(0,1,1,0,0,0, 0,0,2));
    vecs.push_back(mk(0,1,1,0,0,0, 0,0,2));
    vecs.push_back(mk(1,1,1,0,0,0, 1,0,2));
    // T4 load 110 with x=1 (would match old pattern), then 1,1,0
    vecs.push_back(mk(1,1,1,1,6,0, 0,1,3));
    vecs.push_back(mk(1,1,1,0,0,0, 0,0,3));
    vecs.push_back(mk(1,1,1,0,0,0, 0,0,3));
    vecs.push_back(mk(1,0,1,0,0,0, 1,0,3));   // counter saturated at 3
    vecs.push_back(mk(1,0,1,1,5,1, 0,1,3));   // reload 101 and clear
    // T5 saturation, 1,0,1,0,1,0,1,0,1,0,1
    vecs.push_back(mk(1,1,1,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,1,0,0,0, 0,0,0));
    vecs.push_back(mk(1,1,1,0,0,0, 1,0,0));
    vecs.push_back(mk(1,0,1,0,0,0, 0,1,1));
    vecs.push_back(mk(1,1,1,0,0,0, 1,0,1));
    vecs.push_back(mk(1,0,1,0,0,0, 0,1,2));
    vecs.push_back(mk(1,1,1,0,0,0, 1,0,2));
    vecs.push_back(mk(1,0,1,0,0,0, 0,1,3));
    vecs.push_back(mk(1,1,1,0,0,0, 1,0,3));
    vecs.push_back(mk(1,0,1,0,0,0, 0,1,3));
    vecs.push_back(mk(1,1,1,0,0,0, 1,0,3));
    vecs.push_back(mk(1,0,1,0,0,0, 0,1,3));
    vecs.push_back(mk(1,1,1,0,0,1, 1,0,3));   // clear beats coincident match
    vecs.push_back(mk(0,0,1,0,0,0, 0,1,0));
    // overlap sampled on the match cycle only
    vecs.push_back(mk(1,0,1,0,0,0, 0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 1,0,0));
    vecs.push_back(mk(1,0,1,0,0,0, 0,1,1));
    vecs.push_back(mk(1,1,1,0,0,0, 0,0,1));

    // Reset state while rst is held low
    #3;
    chk("rst.z",   {31'd0, z},   32'd0);
    chk("rst.z_q", {31'd0, z_q}, 32'd0);
    chk("rst.cnt", {30'd0, match_cnt}, 32'd0);
    #4;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("v%0d", i));
    end

    // T6: match on pattern 110, then async reset mid-cycle.
    step(mk(1,0,1,1,6,0, 0,0,1), "t6.load");
    step(mk(1,1,1,0,0,0, 0,0,1), "t6.b1");
    step(mk(1,1,1,0,0,0, 0,0,1), "t6.b2");
    step(mk(1,0,1,0,0,0, 1,0,1), "t6.b3");
    step(mk(1,1,1,0,0,0, 0,1,2), "t6.pre");
    en = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("t6.rst.z",   {31'd0, z},   32'd0);
    chk("t6.rst.z_q", {31'd0, z_q}, 32'd0);
    chk("t6.rst.cnt", {30'd0, match_cnt}, 32'd0);
    en = 1'b1;
    x  = 1'b1;
    #1;
    chk("t6.rst.z_en", {31'd0, z}, 32'd0);
    en = 1'b0;
    #1;
    rst = 1'b1;
    // Pattern must be back to 101 (110 would not fire on this stream).
    step(mk(1,1,1,0,0,0, 0,0,0), "t6.r1");
    step(mk(1,0,1,0,0,0, 0,0,0), "t6.r2");
    step(mk(1,1,1,0,0,0, 1,0,0), "t6.r3");
    step(mk(0,0,1,0,0,0, 0,1,1), "t6.r4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
